beat_ctrl: RTL and testbench

Run/stop/step sequencer for the CPU beat ring. It owns an NBEATS-wide one-hot beat register and advances it only when the controller allows. It supports variable-length instructions: the ring returns to beat 0 after the instruction's last beat. It provides free-run, single-step and halt/stop at instruction boundaries, and sits between the front panel / HLT decode and the micro-op decoder, which qualifies every beat with beat_en.

---
 rtl/beat_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_beat_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beat_ctrl.sv
// beat_ctrl -- run/stop/step sequencer for the CPU beat ring.
//
// Owns the one-hot beat register t and advances it only on live beats.
// Instructions are variable length: the ring returns to beat 0 after the
// beat whose index equals last_beat (or after beat NBEATS-1, whichever
// comes first). Free-run, single-step and halt/stop at instruction
// boundaries are supported.
//
// Optional feature macro: BEAT_CTRL_ICNT_EN
//   When defined, adds output instr_cnt[15:0], a wrapping count of
//   completed instructions, cleared when execution restarts from HALTED.
//
// Beat qualification: beat_en is the single "beat is live" qualifier. The
// micro-op decoder acts on the current t only in a cycle where beat_en=1,
// and the ring moves on at the edge closing that cycle. There is no
// back-pressure: a live beat is always consumed in the cycle it is
// offered. In single-step mode a beat goes live only on the cycle in which
// step_req rises; a held step_req produces exactly one live beat.
//
// dbg_state exposes the controller state for observation.

module beat_ctrl #(
  parameter int NBEATS = 8,
  parameter int LW     = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              halt,
  input  logic              step_mode,
  input  logic              step_req,
  input  logic [LW-1:0]     last_beat,
  output logic [NBEATS-1:0] t,
  output logic              beat_en,
  output logic              running,
  output logic              halted,
  output logic              instr_done,
`ifdef BEAT_CTRL_ICNT_EN
  output logic [15:0]       instr_cnt,
`endif
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_STEP   = 2'd2,
    S_HALTED = 2'd3
  } state_e;

  localparam logic [NBEATS-1:0] T_BEAT0 = NBEATS'(1);
  localparam logic [LW-1:0]     TOP_IDX = LW'(NBEATS - 1);

  state_e              state_q, state_d;
  logic [NBEATS-1:0]   t_q, t_d;
  logic                step_req_q;
  logic                instr_done_q;
  logic                running_q;
  logic                halted_q;

  logic                step_rise;
  logic                beat_live;
  logic                last;
  logic [LW-1:0]       cur;

  // Single-step trigger: a rising edge of the (already synchronised) button.
  assign step_rise = step_req & ~step_req_q;

  // A beat is live every cycle in RUN, and only on a button edge in STEP.
  always_comb begin
    beat_live = 1'b0;
    if (state_q == S_RUN) begin
      beat_live = 1'b1;
    end else if (state_q == S_STEP) begin
      beat_live = step_rise;
    end
  end

  // Encode the one-hot ring into the current beat index.
  always_comb begin
    cur = '0;
    for (int i = 0; i < NBEATS; i++) begin
      if (t_q[i]) begin
        cur = LW'(i);
      end
    end
  end

  // Final beat of the instruction: the decoder's last_beat, or the top of
  // the ring when last_beat points past it.
  assign last = beat_live & ((cur == last_beat) | (cur == TOP_IDX));

  // Ring advance: back to beat 0 after the last beat, else rotate left.
  always_comb begin
    t_d = t_q;
    if (beat_live) begin
      if (last) begin
        t_d = T_BEAT0;
      end else begin
        t_d = {t_q[NBEATS-2:0], t_q[NBEATS-1]};
      end
    end
  end

  // Next-state selection. halt/stop are only looked at on the last beat,
  // so the ring is always back at beat 0 when execution stops. A mode
  // switch between RUN and STEP keeps the current beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          state_d = step_mode ? S_STEP : S_RUN;
        end
      end
      S_RUN: begin
        if (last && halt) begin
          state_d = S_HALTED;
        end else if (last && stop) begin
          state_d = S_IDLE;
        end else if (step_mode) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        if (last && halt) begin
          state_d = S_HALTED;
        end else if (last && stop) begin
          state_d = S_IDLE;
        end else if (!step_mode) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Controller registers: state, ring, step edge detector and the status
  // outputs, which are taken from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      t_q          <= T_BEAT0;
      step_req_q   <= 1'b0;
      instr_done_q <= 1'b0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      step_req_q   <= step_req;
      instr_done_q <= last;
      running_q    <= (state_d == S_RUN) || (state_d == S_STEP);
      halted_q     <= (state_d == S_HALTED);
    end
  end

`ifdef BEAT_CTRL_ICNT_EN
  logic [15:0] instr_cnt_q;

  // Completed-instruction counter; a restart from HALTED clears it and
  // takes precedence over a coincident completion.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr_cnt_q <= 16'd0;
    end else if ((state_q == S_HALTED) && start) begin
      instr_cnt_q <= 16'd0;
    end else if (instr_done_q) begin
      instr_cnt_q <= instr_cnt_q + 16'd1;
    end
  end

  assign instr_cnt = instr_cnt_q;
`endif

  assign t          = t_q;
  assign beat_en    = beat_live;
  assign running    = running_q;
  assign halted     = halted_q;
  assign instr_done = instr_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_beat_ctrl.sv
// tb_beat_ctrl -- directed scenarios followed by randomized stimulus, all
// checked cycle by cycle against a behavioural model of the beat ring.
// Define BEAT_CTRL_ICNT_EN for both files to include the instruction counter.

module tb_beat_ctrl;

  localparam int NBEATS = 8;
  localparam int LW     = 3;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic              halt;
  logic              step_mode;
  logic              step_req;
  logic [LW-1:0]     last_beat;
  logic [NBEATS-1:0] t;
  logic              beat_en;
  logic              running;
  logic              halted;
  logic              instr_done;
  logic [1:0]        dbg_state;
`ifdef BEAT_CTRL_ICNT_EN
  logic [15:0]       instr_cnt;
`endif

  always #5 clk = ~clk;

  beat_ctrl #(.NBEATS(NBEATS), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .halt       (halt),
    .step_mode  (step_mode),
    .step_req   (step_req),
    .last_beat  (last_beat),
    .t          (t),
    .beat_en    (beat_en),
    .running    (running),
    .halted     (halted),
    .instr_done (instr_done),
`ifdef BEAT_CTRL_ICNT_EN
    .instr_cnt  (instr_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int beats_seen = 0;

  // ---------------- behavioural model ----------------
  // Executing or not, single-stepping or not, parked after a halt or not,
  // plus the current beat number within the instruction.
  bit m_exec;
  bit m_stepping;
  bit m_halted;
  bit m_done;
  bit m_prev_req;
  int m_beat;
  int m_cnt;

  // Scoreboard: expected beat register for each upcoming cycle.
  logic [NBEATS-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NBEATS-1:0] onehot(input int idx);
    logic [NBEATS-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_exec     = 1'b0;
    m_stepping = 1'b0;
    m_halted   = 1'b0;
    m_done     = 1'b0;
    m_prev_req = 1'b0;
    m_beat     = 0;
    m_cnt      = 0;
    exp_q.delete();
    exp_q.push_back(onehot(0));
  endtask

  // One clock cycle: inputs are already driven. Compare outputs mid-cycle
  // against the model, then advance the model across the rising edge.
  task automatic tick();
    bit                live;
    bit                is_last;
    bit                old_done;
    logic [NBEATS-1:0] exp_t;
    @(negedge clk);
    live    = m_exec && (!m_stepping || (step_req && !m_prev_req));
    is_last = live && ((m_beat == int'(last_beat)) || (m_beat == NBEATS - 1));
    exp_t   = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
    check("t", t, exp_t);
    check("beat_en", beat_en, live);
    check("running", running, m_exec);
    check("halted", halted, m_halted);
    check("instr_done", instr_done, m_done);
`ifdef BEAT_CTRL_ICNT_EN
    check("instr_cnt", instr_cnt, m_cnt[15:0]);
`endif
    if (live) beats_seen++;
    @(posedge clk);
    old_done = m_done;
    if (live) m_beat = is_last ? 0 : m_beat + 1;
    m_done     = is_last;
    m_prev_req = step_req;
    if (m_halted && start) m_cnt = 0;
    else if (old_done) m_cnt = (m_cnt + 1) & 16'hFFFF;
    if (!m_exec) begin
      if (start) begin
        m_exec     = 1'b1;
        m_stepping = step_mode;
        m_halted   = 1'b0;
      end
    end else if (is_last && halt) begin
      m_exec   = 1'b0;
      m_halted = 1'b1;
    end else if (is_last && stop) begin
      m_exec   = 1'b0;
      m_halted = 1'b0;
    end else begin
      m_stepping = step_mode;
    end
    exp_q.push_back(onehot(m_beat));
    #1;
  endtask

  task automatic pulse_start(input logic mode);
    step_mode = mode;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #400000;
    $display("FAIL watchdog expired at %0t", $time);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic new_mode;
    reset     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    halt      = 1'b0;
    step_mode = 1'b0;
    step_req  = 1'b0;
    last_beat = 3'd7;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_t", t, 8'h01);
    check("rst_beat_en", beat_en, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_instr_done", instr_done, 1'b0);
    reset = 1'b1;

    // Full-length instruction in free-run.
    pulse_start(1'b0);
    repeat (8) tick();
    check("full_wrap_t", t, 8'h01);
    check("full_wrap_done", instr_done, 1'b1);

    // Four-beat instructions, three of them.
    last_beat = 3'd3;
    repeat (12) tick();
    check("len4_t", t, 8'h01);
    check("len4_done", instr_done, 1'b1);

    // Halt raised mid-instruction takes effect at the boundary.
    last_beat = 3'd5;
    repeat (2) tick();
    check("halt_at_t04", t, 8'h04);
    halt = 1'b1;
    repeat (4) tick();
    halt = 1'b0;
    check("halt_t", t, 8'h01);
    check("halt_halted", halted, 1'b1);
    check("halt_running", running, 1'b0);
    check("halt_beat_en", beat_en, 1'b0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("halt_ignores_stop", halted, 1'b1);
    pulse_start(1'b0);
    check("resume_running", running, 1'b1);
    check("resume_t", t, 8'h01);

    // Halt beats stop when both are present on the last beat.
    last_beat = 3'd1;
    tick();
    stop = 1'b1;
    halt = 1'b1;
    tick();
    stop = 1'b0;
    halt = 1'b0;
    check("both_halted", halted, 1'b1);
    pulse_start(1'b0);
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_halted", halted, 1'b0);
    check("stop_running", running, 1'b0);

    // Single-step: a held button yields one beat, then two clean pulses.
    last_beat = 3'd7;
    pulse_start(1'b1);
    beats_seen = 0;
    step_req = 1'b1;
    repeat (5) tick();
    step_req = 1'b0;
    tick();
    repeat (2) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick();
    end
    check("step_beats", beats_seen, 3);
    check("step_t", t, 8'h08);
    step_mode = 1'b0;
    repeat (3) tick();

    // Asynchronous reset in the middle of an instruction.
    for (int i = 0; i < 16 && m_beat != 4; i++) tick();
    check("pre_reset_t", t, 8'h10);
    #2;
    reset = 1'b0;
    #1;
    check("async_t", t, 8'h01);
    check("async_done", instr_done, 1'b0);
    check("async_beat_en", beat_en, 1'b0);
    check("async_running", running, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // One-beat instructions: the ring never leaves beat 0.
    last_beat = 3'd0;
    pulse_start(1'b0);
    repeat (4) tick();
    check("len1_t", t, 8'h01);
    check("len1_done", instr_done, 1'b1);

    // Randomized operation.
    for (int n = 0; n < 3000; n++) begin
      start     = ($urandom_range(0, 9) == 0);
      step_req  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) last_beat = LW'($urandom_range(0, 7));
      new_mode  = ($urandom_range(0, 49) == 0) ? ~step_mode : step_mode;
      step_mode = new_mode;
      if (m_exec && (m_stepping != new_mode)) begin
        stop = 1'b0;
        halt = 1'b0;
      end else begin
        stop = ($urandom_range(0, 15) == 0);
        halt = ($urandom_range(0, 19) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
